updown_step_counter: RTL and testbench

- Parametrised synchronous up/down binary counter; generalises the team's fixed 4-bit even up/down T-flip-flop counter.
- Adds: configurable width, runtime step mode (all / even / odd / hold), count enable, parallel load, wrap or saturate at the range ends, terminal-count flag and a registered wrap pulse.
- Used as a general sequencing/counting primitive in the lab datapaths.

---
 rtl/updown_step_counter.sv | 97 +++++++++
 tb/tb_updown_step_counter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/updown_step_counter.sv
// updown_step_counter: parametrised synchronous up/down counter with a
// runtime step mode (all / even / odd / hold), count enable, parallel load,
// wrap-or-saturate behaviour at the range ends, a combinational terminal
// count flag and a registered one-cycle wrap pulse.
//
// Range ends are never compared explicitly. Once the count parity matches
// the mode, adding or subtracting the step overflows or borrows out of the
// WIDTH-bit range exactly when the count sits on the range end for the
// current direction. Because of that, the carry/borrow bit doubles as the
// "at end" indication. It is used for the wrap pulse, for saturation and
// for tc.
module updown_step_counter #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped
);

  localparam logic [1:0] MODE_ALL  = 2'b00;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             wrapped_reg;
  logic             wrapped_next;

  // Mode decode: modes 01/10 step by two and fix the LSB.
  // mode[1] happens to be the required LSB value (01 -> 0, 10 -> 1).
  logic             mode_hold;
  logic             parity_mode;
  logic             parity_bit;
  logic             misaligned;
  logic [WIDTH-1:0] step_amt;

  assign mode_hold   = (mode == MODE_HOLD);
  assign parity_mode = (mode != MODE_ALL) && !mode_hold;
  assign parity_bit  = mode[1];
  assign misaligned  = parity_mode && (count_reg[0] != parity_bit);
  assign step_amt    = parity_mode ? WIDTH'(2) : WIDTH'(1);

  // One extra bit captures carry (up) or borrow (down) out of the range.
  logic [WIDTH:0] sum_up;
  logic [WIDTH:0] diff_dn;
  logic           at_end;

  assign sum_up  = {1'b0, count_reg} + {1'b0, step_amt};
  assign diff_dn = {1'b0, count_reg} - {1'b0, step_amt};
  assign at_end  = up ? sum_up[WIDTH] : diff_dn[WIDTH];

  // Next-state selection in priority order: load, hold, align, then step.
  // Reset is handled in the register block.
  always_comb begin
    count_next   = count_reg;
    wrapped_next = 1'b0;
    if (load) begin
      count_next = load_val;
    end else if (!en || mode_hold) begin
      count_next = count_reg;
    end else if (misaligned) begin
      // Alignment edge: only the LSB changes, and no step is taken.
      count_next = {count_reg[WIDTH-1:1], parity_bit};
    end else if (at_end && SATURATE) begin
      count_next = count_reg;
    end else begin
      count_next   = up ? sum_up[WIDTH-1:0] : diff_dn[WIDTH-1:0];
      wrapped_next = at_end;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg   <= '0;
      wrapped_reg <= 1'b0;
    end else begin
      count_reg   <= count_next;
      wrapped_reg <= wrapped_next;
    end
  end

  assign count   = count_reg;
  assign wrapped = wrapped_reg;

  // tc is asserted on an aligned count in an active mode when the next
  // step would leave the range in the current direction.
  assign tc = !mode_hold && !misaligned && at_end;

endmodule

// File: tb/tb_updown_step_counter.sv
// Scoreboard bench for updown_step_counter (WIDTH = 4).
// Two instances receive identical stimulus: one wraps and one saturates.
// A range-based reference model predicts each edge. The stimulus side
// pushes the expected results into a queue, and a separate monitor pops
// them one edge later and compares them with the DUT outputs.
module tb_updown_step_counter;

  localparam int W = 4;
  localparam int M = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count_w, count_s;
  logic         tc_w, tc_s, wrapped_w, wrapped_s;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  updown_step_counter #(.WIDTH(W), .SATURATE(1'b0)) dut_wrap (
    .clock(clock), .reset(reset), .en(en), .up(up), .mode(mode),
    .load(load), .load_val(load_val),
    .count(count_w), .tc(tc_w), .wrapped(wrapped_w)
  );

  updown_step_counter #(.WIDTH(W), .SATURATE(1'b1)) dut_sat (
    .clock(clock), .reset(reset), .en(en), .up(up), .mode(mode),
    .load(load), .load_val(load_val),
    .count(count_s), .tc(tc_s), .wrapped(wrapped_s)
  );

  typedef struct {
    int cnt_w; int wr_w; int tc_w;
    int cnt_s; int wr_s; int tc_s;
  } exp_t;

  exp_t exp_q[$];

  // Model state for each instance.
  int m_cnt_w = 0;
  int m_cnt_s = 0;

  function automatic int range_lo(input int md);
    return (md == 2) ? 1 : 0;
  endfunction

  function automatic int range_hi(input int md);
    return (md == 1) ? M - 1 : M;
  endfunction

  function automatic int parity_ok(input int c, input int md);
    if (md == 1) return (c % 2 == 0) ? 1 : 0;
    if (md == 2) return (c % 2 == 1) ? 1 : 0;
    return 1;
  endfunction

  function automatic int model_tc(input int c, input int u, input int md);
    if (md == 3) return 0;
    if (parity_ok(c, md) == 0) return 0;
    if (u != 0) return (c == range_hi(md)) ? 1 : 0;
    return (c == range_lo(md)) ? 1 : 0;
  endfunction

  // Reference rule for one edge: returns the new count and sets wr to the wrap flag.
  function automatic int model_next(input int c, input int sat, input int r, input int ld,
                                    input int lv, input int e, input int u, input int md,
                                    output int wr);
    int step;
    wr = 0;
    if (r != 0) return 0;
    if (ld != 0) return lv;
    if (e == 0 || md == 3) return c;
    if (parity_ok(c, md) == 0) return (c / 2) * 2 + ((md == 2) ? 1 : 0);
    step = (md == 0) ? 1 : 2;
    if (u != 0) begin
      if (c == range_hi(md)) begin
        if (sat != 0) return c;
        wr = 1;
        return range_lo(md);
      end
      return c + step;
    end else begin
      if (c == range_lo(md)) begin
        if (sat != 0) return c;
        wr = 1;
        return range_hi(md);
      end
      return c - step;
    end
  endfunction

  // Drive one edge's inputs and push the predicted post-edge outputs.
  task automatic drive(input int r, input int ld, input int lv, input int e,
                       input int u, input int md);
    exp_t x;
    int wr;
    @(negedge clock);
    reset    = r[0];
    load     = ld[0];
    load_val = lv[W-1:0];
    en       = e[0];
    up       = u[0];
    mode     = md[1:0];
    m_cnt_w  = model_next(m_cnt_w, 0, r, ld, lv, e, u, md, wr);
    x.cnt_w  = m_cnt_w;
    x.wr_w   = wr;
    x.tc_w   = model_tc(m_cnt_w, u, md);
    m_cnt_s  = model_next(m_cnt_s, 1, r, ld, lv, e, u, md, wr);
    x.cnt_s  = m_cnt_s;
    x.wr_s   = wr;
    x.tc_s   = model_tc(m_cnt_s, u, md);
    exp_q.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: after each rising edge, compare the DUT with the queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        $display("edge t=%0t rst=%0b ld=%0b en=%0b up=%0b mode=%0d | wrap: cnt=%0d tc=%0b wr=%0b | sat: cnt=%0d tc=%0b wr=%0b",
                 $time, reset, load, en, up, mode, count_w, tc_w, wrapped_w,
                 count_s, tc_s, wrapped_s);
        check("wrap_count",   32'(count_w),   x.cnt_w);
        check("wrap_wrapped", 32'(wrapped_w), x.wr_w);
        check("wrap_tc",      32'(tc_w),      x.tc_w);
        check("sat_count",    32'(count_s),   x.cnt_s);
        check("sat_wrapped",  32'(wrapped_s), x.wr_s);
        check("sat_tc",       32'(tc_s),      x.tc_s);
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin
    int wait_cycles;
    // Reset with load and en active; reset must win.
    repeat (2) drive(1, 1, 9, 1, 1, 1);
    // Even up-count through the wrap (2..14, 0, 2).
    repeat (9) drive(0, 0, 0, 1, 1, 1);
    // Back to 0, then even down-count through the wrap.
    drive(1, 0, 0, 0, 0, 1);
    repeat (9) drive(0, 0, 0, 1, 0, 1);
    // Odd mode from reset: align 0 -> 1, then step through 15 -> 1.
    drive(1, 0, 0, 0, 1, 2);
    repeat (10) drive(0, 0, 0, 1, 1, 2);
    // Load 7 in even mode, then realign to 6 and step to 8 and 10.
    drive(0, 1, 7, 1, 1, 1);
    repeat (3) drive(0, 0, 0, 1, 1, 1);
    // Hold mode with en = 1.
    repeat (2) drive(0, 0, 0, 1, 1, 3);
    // Count up from 13 in mode 00 (one instance saturates, one wraps).
    drive(0, 1, 13, 0, 1, 0);
    repeat (5) drive(0, 0, 0, 1, 1, 0);
    // Count down from 1 in mode 00 to the low end.
    drive(0, 1, 1, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 1, 0, 0);
    // Direction flip mid-count.
    drive(0, 1, 5, 0, 1, 0);
    drive(0, 0, 0, 1, 1, 0);
    repeat (2) drive(0, 0, 0, 1, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 31) == 0) ? 1 : 0,
            ($urandom_range(0, 7) == 0) ? 1 : 0,
            int'($urandom_range(0, M)),
            ($urandom_range(0, 3) != 0) ? 1 : 0,
            int'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)));
    end
    // Drain the scoreboard within a bounded number of cycles.
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clock);
      wait_cycles++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual %0d required 0 pending entries", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
